// File: rtl/reset_pkg.sv
// Shared types and default constants for the staged reset sequencer.
// Provides the FSM state enum and a small max helper for counter sizing.
package reset_pkg;

  typedef enum logic [1:0] {
    S_RELEASE,
    S_RUN,
    S_QUIESCE,
    S_HOLD
  } state_e;

  localparam int DEF_NUM_DOMAINS     = 3;
  localparam int DEF_STAGE_DELAY     = 16;
  localparam int DEF_HOLD_CYCLES     = 8;
  localparam int DEF_QUIESCE_TIMEOUT = 64;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Per-domain reset/quiesce bundle between the sequencer and the SoC domains.
// master: sequencer side (drives resets, quiesce, acks); slave: SoC side.
interface reset_sequencer_if
  import reset_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);
  logic [NUM_DOMAINS-1:0] SOFT_RST_REQ;
  logic [NUM_DOMAINS-1:0] QUIESCE_ACK;
  logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N;
  logic [NUM_DOMAINS-1:0] QUIESCE_REQ;
  logic [NUM_DOMAINS-1:0] SOFT_RST_ACK;
  logic                   SEQ_DONE;
  logic [NUM_DOMAINS-1:0] TIMEOUT_ERR;

  modport master (
    input  SOFT_RST_REQ, QUIESCE_ACK,
    output DOMAIN_RESET_N, QUIESCE_REQ,
    output SOFT_RST_ACK, SEQ_DONE, TIMEOUT_ERR
  );

  modport slave (
    output SOFT_RST_REQ, QUIESCE_ACK,
    input  DOMAIN_RESET_N, QUIESCE_REQ,
    input  SOFT_RST_ACK, SEQ_DONE, TIMEOUT_ERR
  );
endinterface

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asynchronous assert, synchronous deassert.
// Ports: clk_i clock, rst_ni raw active-low reset, rst_no synced reset.
module reset_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_no = sync_q[1];
endmodule

// File: rtl/reset_sequencer.sv
// Staged power-up reset release plus per-domain quiesced soft resets.
// Ports: CLK, FABRIC_RESET_N (async, active low), bus (master modport).
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_DOMAINS     = DEF_NUM_DOMAINS,
  parameter int STAGE_DELAY     = DEF_STAGE_DELAY,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int QUIESCE_TIMEOUT = DEF_QUIESCE_TIMEOUT
) (
  input  logic CLK,
  input  logic FABRIC_RESET_N,
  reset_sequencer_if.master bus
);
  localparam int CW = $clog2(max3(STAGE_DELAY, HOLD_CYCLES,
                                  QUIESCE_TIMEOUT)) + 1;
  localparam int SW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int N  = NUM_DOMAINS;

  localparam logic [CW-1:0] SD_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(QUIESCE_TIMEOUT - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(N - 1);
  localparam logic [N-1:0]  ONE     = N'(1);

  logic          rst_sync_n;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [SW-1:0] sel_q, sel_d, pick;
  logic [N-1:0]  pend_q, pend_d;
  logic          done_q, done_d;
  logic [N-1:0]  sel_oh, stage_oh, pick_oh;
  logic          ack_hit, stage_end, to_hit;

  logic [N-1:0]  dom_n_q, dom_n_d;
  logic [N-1:0]  qreq_q, qreq_d;
  logic [N-1:0]  sack_q, sack_d;
  logic [N-1:0]  err_q, err_d;
  logic          seq_q, seq_d;

  reset_sync u_sync (
    .clk_i  (CLK),
    .rst_ni (FABRIC_RESET_N),
    .rst_no (rst_sync_n)
  );

  assign sel_oh    = ONE << sel_q;
  assign stage_oh  = ONE << stage_q;
  assign pick_oh   = ONE << pick;
  assign ack_hit   = |(bus.QUIESCE_ACK & sel_oh);
  assign stage_end = (cnt_q == SD_LAST);
  assign to_hit    = (cnt_q == TO_LAST);

  // lowest-index pending domain wins
  always_comb begin
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) pick = SW'(i);
    end
  end

  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= S_RELEASE;
      cnt_q   <= '0;
      stage_q <= '0;
      sel_q   <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    stage_d = stage_q;
    sel_d   = sel_q;
    pend_d  = pend_q | bus.SOFT_RST_REQ;
    done_d  = 1'b0;
    unique case (state_q)
      S_RELEASE: begin
        if (stage_end) begin
          cnt_d   = '0;
          stage_d = stage_q + SW'(1);
          if (stage_q == ST_LAST) state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (|pend_q) begin
          sel_d   = pick;
          pend_d  = (pend_q & ~pick_oh) | bus.SOFT_RST_REQ;
          state_d = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        if (ack_hit || to_hit) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == HD_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RELEASE;
    endcase
  end

  // outputs are registered one cycle behind the state they reflect
  always_comb begin
    dom_n_d = '1;
    qreq_d  = '0;
    sack_d  = done_q ? sel_oh : '0;
    err_d   = err_q;
    seq_d   = seq_q;
    unique case (state_q)
      S_RELEASE: begin
        dom_n_d = dom_n_q | (stage_end ? stage_oh : '0);
        seq_d   = stage_end && (stage_q == ST_LAST);
      end
      S_QUIESCE: begin
        qreq_d = sel_oh;
        if (!ack_hit && to_hit) err_d = err_q | sel_oh;
      end
      S_HOLD:  dom_n_d = ~sel_oh;
      default: dom_n_d = '1;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      dom_n_q <= '0;
      qreq_q  <= '0;
      sack_q  <= '0;
      err_q   <= '0;
      seq_q   <= 1'b0;
    end else begin
      dom_n_q <= dom_n_d;
      qreq_q  <= qreq_d;
      sack_q  <= sack_d;
      err_q   <= err_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.DOMAIN_RESET_N = dom_n_q;
  assign bus.QUIESCE_REQ    = qreq_q;
  assign bus.SOFT_RST_ACK   = sack_q;
  assign bus.TIMEOUT_ERR    = err_q;
  assign bus.SEQ_DONE       = seq_q;
endmodule
